// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way (NS/EW) intersection light sequencer with a
// per-phase seconds countdown and a force-red hold.
//   clk, rst        : clock and asynchronous active-high reset
//   en              : run enable; 0 freezes the prescaler and the countdown
//   force_red       : level request to hold every direction red
//   ns_light        : NS lamps {R,Y,G}, one-hot, registered
//   ew_light        : EW lamps {R,Y,G}, one-hot, registered
//   count           : remaining seconds of the current phase (binary)
//   phase           : current state code
//   phase_start     : one-cycle pulse on the first cycle of a new phase
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GREEN_S  = 30,
  parameter int unsigned YELLOW_S = 3,
  parameter int unsigned ALLRED_S = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       force_red,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [7:0] count,
  output logic [2:0] phase,
  output logic       phase_start
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] GREEN_D  = 8'(GREEN_S);
  localparam logic [7:0] YELLOW_D = 8'(YELLOW_S);
  localparam logic [7:0] ALLRED_D = 8'(ALLRED_S);
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    HOLD = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic            start_nxt;
  logic [2:0]      ns_nxt, ew_nxt;
  logic            hold_like_c;
  logic            tick_c;

  // Illegal code 7 is treated exactly like HOLD.
  assign hold_like_c = (3'(state) >= 3'd6);
  assign tick_c      = en && (presc == PRESC_MAX);

  // Next-state, countdown, prescaler and lamp decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = count;
    presc_nxt = presc;
    start_nxt = 1'b0;
    ns_nxt    = LAMP_R;
    ew_nxt    = LAMP_R;

    if (force_red) begin
      // force_red outranks en and tick; only the entry edge pulses.
      state_nxt = HOLD;
      cnt_nxt   = 8'd0;
      presc_nxt = '0;
      start_nxt = !hold_like_c;
    end else if (hold_like_c) begin
      // Leave HOLD through a clearance interval before NS green.
      state_nxt = AR_B;
      cnt_nxt   = ALLRED_D;
      presc_nxt = '0;
      start_nxt = 1'b1;
    end else if (en) begin
      if (tick_c) begin
        presc_nxt = '0;
        if (count > 8'd1) begin
          cnt_nxt = count - 8'd1;
        end else begin
          start_nxt = 1'b1;
          case (state)
            NS_G:    begin state_nxt = NS_Y; cnt_nxt = YELLOW_D; end
            NS_Y:    begin state_nxt = AR_A; cnt_nxt = ALLRED_D; end
            AR_A:    begin state_nxt = EW_G; cnt_nxt = GREEN_D;  end
            EW_G:    begin state_nxt = EW_Y; cnt_nxt = YELLOW_D; end
            EW_Y:    begin state_nxt = AR_B; cnt_nxt = ALLRED_D; end
            AR_B:    begin state_nxt = NS_G; cnt_nxt = GREEN_D;  end
            default: begin state_nxt = HOLD; cnt_nxt = 8'd0;     end
          endcase
        end
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end

    // Lamps follow the next state so they change on the same edge as phase.
    case (state_nxt)
      NS_G:    begin ns_nxt = LAMP_G; ew_nxt = LAMP_R; end
      NS_Y:    begin ns_nxt = LAMP_Y; ew_nxt = LAMP_R; end
      EW_G:    begin ns_nxt = LAMP_R; ew_nxt = LAMP_G; end
      EW_Y:    begin ns_nxt = LAMP_R; ew_nxt = LAMP_Y; end
      default: begin ns_nxt = LAMP_R; ew_nxt = LAMP_R; end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NS_G;
      count       <= GREEN_D;
      presc       <= '0;
      phase_start <= 1'b0;
      ns_light    <= LAMP_G;
      ew_light    <= LAMP_R;
    end else begin
      state       <= state_nxt;
      count       <= cnt_nxt;
      presc       <= presc_nxt;
      phase_start <= start_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
    end
  end

  assign phase = 3'(state);

endmodule
